// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port dmem arbiter.
package dmem_arb_pkg;

  localparam int N_REQ = 2;

  // One request as presented by a requester port.
  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // Tag that travels alongside each read through the response pipe.
  typedef struct packed {
    logic valid;
    logic owner;
    logic err;
  } rsp_tag_t;

  // True when a byte address lies inside a dmem of depth_words 32-bit words.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned depth_words);
    return ({2'b00, addr} < (34'(depth_words) << 2));
  endfunction

endpackage

// File: rtl/dmem_arb_rsp_pipe.sv
// Response tag delay line: one slot per issued read, so responses come back
// in issue order at a fixed latency, whether or not dmem was actually accessed.
module dmem_arb_rsp_pipe
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t stage_q [DEPTH];
  rsp_tag_t stage_d [DEPTH];

  // Shift the tags one stage per cycle.
  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Reset drops every in-flight read so nothing responds after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port dmem arbiter: port 0 (LSU) has fixed priority, port 1 (DMA) is
// protected from starvation by a bounded run counter. Requests are range and
// alignment checked before they reach dmem; reads return in order.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH_WORDS  = 256,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][3:0]  req_be,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  output logic [1:0]       rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [15:0]      err_cnt,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic [3:0]       wr_en,
  output logic [31:0]      rd_addr,
  input  logic [31:0]      rd_data
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [3:0]      wr_en_q, wr_en_d;
  logic [31:0]     wr_addr_q, wr_addr_d;
  logic [31:0]     wr_data_q, wr_data_d;
  logic [31:0]     rd_addr_q, rd_addr_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  dmem_req_t sel_req;
  rsp_tag_t  tag_in, tag_out;
  logic      starved, gnt_any, is_read, in_range, aligned;
  logic      rd_ok, wr_ok, wr_bad;

  // Port 1 only overtakes port 0 once it has lost STARVE_LIMIT times in a row.
  assign starved = (starve_cnt_q == SC_MAX) && req_valid[1];

  // Grant: at most one port per cycle.
  always_comb begin
    req_ready = 2'b00;
    if (req_valid[0] && !starved) begin
      req_ready[0] = 1'b1;
    end else if (req_valid[1]) begin
      req_ready[1] = 1'b1;
    end
  end

  assign gnt_any = |req_ready;

  // Select the winning request and classify it.
  always_comb begin
    sel_req.be    = req_ready[1] ? req_be[1]    : req_be[0];
    sel_req.addr  = req_ready[1] ? req_addr[1]  : req_addr[0];
    sel_req.wdata = req_ready[1] ? req_wdata[1] : req_wdata[0];
    is_read  = (sel_req.be == 4'b0000);
    in_range = addr_in_range(sel_req.addr, DEPTH_WORDS);
    aligned  = (sel_req.addr[1:0] == 2'b00);
    rd_ok    = gnt_any && is_read && in_range && aligned;
    wr_ok    = gnt_any && !is_read && in_range;
    wr_bad   = gnt_any && !is_read && !in_range;
  end

  // Next-state for the starvation counter, dmem issue registers and err_cnt.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!req_valid[1] || req_ready[1]) begin
      starve_cnt_d = '0;
    end else if (req_ready[0] && (starve_cnt_q != SC_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    wr_en_d   = wr_ok ? sel_req.be : 4'b0000;
    wr_addr_d = wr_ok ? {sel_req.addr[31:2], 2'b00} : wr_addr_q;
    wr_data_d = wr_ok ? sel_req.wdata : wr_data_q;
    rd_addr_d = rd_ok ? sel_req.addr : rd_addr_q;

    err_cnt_d = err_cnt_q;
    if (wr_bad && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // State and dmem-side registers; dmem sees a handshake one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      wr_en_q      <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_addr_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_addr_q    <= rd_addr_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Every granted read, good or bad, takes a slot so ordering is preserved.
  always_comb begin
    tag_in.valid = gnt_any && is_read;
    tag_in.owner = req_ready[1];
    tag_in.err   = !(in_range && aligned);
  end

  dmem_arb_rsp_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Route the response to its owner; errored reads return zero data.
  always_comb begin
    rsp_valid = 2'b00;
    if (tag_out.valid) begin
      rsp_valid[tag_out.owner] = 1'b1;
    end
    rsp_err   = tag_out.valid && tag_out.err;
    rsp_rdata = (tag_out.valid && !tag_out.err) ? rd_data : 32'h0;
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = rd_addr_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered, write-before-read dmem model.
module tb_dmem_arbiter;

  localparam int DEPTH_WORDS  = 256;
  localparam int RD_LAT       = 1;
  localparam int STARVE_LIMIT = 4;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][3:0]  req_be;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic [15:0]      err_cnt;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic [3:0]       wr_en;
  logic [31:0]      rd_addr;
  logic [31:0]      rd_data;

  int n_vec;
  int n_fail;

  dmem_arbiter #(
    .DEPTH_WORDS  (DEPTH_WORDS),
    .RD_LAT       (RD_LAT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .err_cnt   (err_cnt),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem model: one-cycle registered read, a same-cycle write is visible to the read.
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mem_wword;

  always_comb begin
    mem_wword = mem[wr_addr[9:2]];
    for (int b = 0; b < 4; b++) begin
      if (wr_en[b]) mem_wword[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en != 4'b0000) mem[wr_addr[9:2]] <= mem_wword;
    rd_data <= ((wr_en != 4'b0000) && (wr_addr[9:2] == rd_addr[9:2])) ? mem_wword : mem[rd_addr[9:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    req_valid[p] = 1'b1;
    req_be[p]    = be;
    req_addr[p]  = a;
    req_wdata[p] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; req_be = '0; req_addr = '0; req_wdata = '0;
    #12;
    n_vec++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    n_vec++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_vec++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_err_cnt: got %h want 0000", err_cnt); end
    n_vec++; if (wr_en !== 4'h0) begin n_fail++; $display("FAIL reset_wr_en: got %h want 0", wr_en); end
    n_vec++; if (rd_addr !== 32'h0) begin n_fail++; $display("FAIL reset_rd_addr: got %h want 0", rd_addr); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rw_basic();
    tick();
    drive(1, 4'hF, 32'h10, 32'hDEADBEEF);
    #1;
    n_vec++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL t1_ready_wr: got %b want 10", req_ready); end
    tick();
    n_vec++; if (wr_en !== 4'hF) begin n_fail++; $display("FAIL t1_wr_en: got %h want F", wr_en); end
    n_vec++; if (wr_addr !== 32'h10) begin n_fail++; $display("FAIL t1_wr_addr: got %h want 00000010", wr_addr); end
    n_vec++; if (wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t1_wr_data: got %h want deadbeef", wr_data); end
    drive(1, 4'h0, 32'h10, 32'h0);
    tick();
    req_valid = '0;
    n_vec++; if (wr_en !== 4'h0) begin n_fail++; $display("FAIL t1_wr_en_rd: got %h want 0", wr_en); end
    n_vec++; if (rd_addr !== 32'h10) begin n_fail++; $display("FAIL t1_rd_addr: got %h want 00000010", rd_addr); end
    n_vec++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL t1_rsp_early: got %b want 00", rsp_valid); end
    tick();
    n_vec++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL t1_rsp_valid: got %b want 10", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t1_rsp_rdata: got %h want deadbeef", rsp_rdata); end
    n_vec++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL t1_rsp_err: got %b want 0", rsp_err); end
    tick();
    n_vec++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL t1_rsp_pulse: got %b want 00", rsp_valid); end
  endtask

  task automatic test_starvation();
    logic [1:0] exp_g;
    logic [1:0] exp_r;
    tick();
    drive(1, 4'hF, 32'h40, 32'h0A0A0A0A);
    tick();
    drive(1, 4'hF, 32'h44, 32'h0B0B0B0B);
    tick();
    drive(0, 4'h0, 32'h40, 32'h0);
    drive(1, 4'h0, 32'h44, 32'h0);
    for (int k = 0; k < 14; k++) begin
      if (k == 12) req_valid = '0;
      #1;
      if (k < 12) begin
        exp_g = ((k % 5) == 4) ? 2'b10 : 2'b01;
        n_vec++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL t2_grant[%0d]: got %b want %b", k, req_ready, exp_g); end
      end
      if (k >= 2) begin
        exp_r = (((k - 2) % 5) == 4) ? 2'b10 : 2'b01;
        n_vec++; if (rsp_valid !== exp_r) begin n_fail++; $display("FAIL t2_rsp_owner[%0d]: got %b want %b", k, rsp_valid, exp_r); end
        n_vec++; if (rsp_rdata !== (exp_r[1] ? 32'h0B0B0B0B : 32'h0A0A0A0A)) begin
          n_fail++; $display("FAIL t2_rsp_rdata[%0d]: got %h want %h", k, rsp_rdata, exp_r[1] ? 32'h0B0B0B0B : 32'h0A0A0A0A);
        end
      end else begin
        n_vec++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL t2_rsp_idle[%0d]: got %b want 00", k, rsp_valid); end
      end
      tick();
    end
  endtask

  task automatic test_err_read();
    drive(0, 4'h0, 32'h3FF, 32'h0);
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL t3_ready: got %b want 01", req_ready); end
    tick();
    drive(0, 4'h0, 32'h400, 32'h0);
    n_vec++; if (rd_addr !== 32'h40) begin n_fail++; $display("FAIL t3_rd_addr_a: got %h want 00000040", rd_addr); end
    tick();
    req_valid = '0;
    n_vec++; if (rd_addr !== 32'h40) begin n_fail++; $display("FAIL t3_rd_addr_b: got %h want 00000040", rd_addr); end
    n_vec++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL t3_rsp_valid_a: got %b want 01", rsp_valid); end
    n_vec++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL t3_rsp_err_a: got %b want 1", rsp_err); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL t3_rdata_a: got %h want 0", rsp_rdata); end
    tick();
    n_vec++; if (rd_addr !== 32'h40) begin n_fail++; $display("FAIL t3_rd_addr_c: got %h want 00000040", rd_addr); end
    n_vec++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL t3_rsp_valid_b: got %b want 01", rsp_valid); end
    n_vec++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL t3_rsp_err_b: got %b want 1", rsp_err); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL t3_rdata_b: got %h want 0", rsp_rdata); end
    tick();
    n_vec++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL t3_rsp_end: got %b want 00", rsp_valid); end
    n_vec++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL t3_err_end: got %b want 0", rsp_err); end
  endtask

  task automatic test_err_write();
    drive(1, 4'hF, 32'h1000, 32'h55555555);
    tick();
    n_vec++; if (wr_en !== 4'h0) begin n_fail++; $display("FAIL t4_wr_en_a: got %h want 0", wr_en); end
    tick();
    n_vec++; if (wr_en !== 4'h0) begin n_fail++; $display("FAIL t4_wr_en_b: got %h want 0", wr_en); end
    tick();
    req_valid = '0;
    n_vec++; if (wr_en !== 4'h0) begin n_fail++; $display("FAIL t4_wr_en_c: got %h want 0", wr_en); end
    n_vec++; if (err_cnt !== 16'd3) begin n_fail++; $display("FAIL t4_err_cnt3: got %h want 0003", err_cnt); end
    drive(1, 4'hF, 32'h1000, 32'h55555555);
    repeat (65531) tick();
    n_vec++; if (err_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL t4_err_cnt_fffe: got %h want fffe", err_cnt); end
    tick();
    n_vec++; if (err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL t4_err_cnt_ffff: got %h want ffff", err_cnt); end
    tick();
    tick();
    req_valid = '0;
    n_vec++; if (err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL t4_err_cnt_sat: got %h want ffff", err_cnt); end
    n_vec++; if (wr_en !== 4'h0) begin n_fail++; $display("FAIL t4_wr_en_sat: got %h want 0", wr_en); end
  endtask

  task automatic test_reset_inflight();
    tick();
    drive(0, 4'h0, 32'h10, 32'h0);
    tick();
    req_valid = '0;
    n_vec++; if (rd_addr !== 32'h10) begin n_fail++; $display("FAIL t5_rd_issued: got %h want 00000010", rd_addr); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL t5_ready: got %b want 00", req_ready); end
    n_vec++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL t5_rsp_valid: got %b want 00", rsp_valid); end
    n_vec++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL t5_rsp_err: got %b want 0", rsp_err); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL t5_rsp_rdata: got %h want 0", rsp_rdata); end
    n_vec++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL t5_err_cnt: got %h want 0000", err_cnt); end
    n_vec++; if (wr_en !== 4'h0) begin n_fail++; $display("FAIL t5_wr_en: got %h want 0", wr_en); end
    n_vec++; if (wr_addr !== 32'h0) begin n_fail++; $display("FAIL t5_wr_addr: got %h want 0", wr_addr); end
    n_vec++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL t5_wr_data: got %h want 0", wr_data); end
    n_vec++; if (rd_addr !== 32'h0) begin n_fail++; $display("FAIL t5_rd_addr: got %h want 0", rd_addr); end
    tick();
    rst_n = 1'b1;
    n_vec++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL t5_no_rsp_a: got %b want 00", rsp_valid); end
    tick();
    n_vec++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL t5_no_rsp_b: got %b want 00", rsp_valid); end
    tick();
    n_vec++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL t5_no_rsp_c: got %b want 00", rsp_valid); end
  endtask

  task automatic test_partial_write();
    drive(0, 4'hF, 32'h20, 32'h11223344);
    tick();
    drive(0, 4'b0011, 32'h22, 32'h0000AAAA);
    n_vec++; if (wr_en !== 4'hF) begin n_fail++; $display("FAIL t6_wr_en_full: got %h want F", wr_en); end
    n_vec++; if (wr_data !== 32'h11223344) begin n_fail++; $display("FAIL t6_wr_data_full: got %h want 11223344", wr_data); end
    tick();
    drive(0, 4'h0, 32'h20, 32'h0);
    n_vec++; if (wr_en !== 4'b0011) begin n_fail++; $display("FAIL t6_wr_en_part: got %h want 3", wr_en); end
    n_vec++; if (wr_addr !== 32'h20) begin n_fail++; $display("FAIL t6_wr_addr_align: got %h want 00000020", wr_addr); end
    tick();
    req_valid = '0;
    n_vec++; if (rd_addr !== 32'h20) begin n_fail++; $display("FAIL t6_rd_addr: got %h want 00000020", rd_addr); end
    n_vec++; if (wr_en !== 4'h0) begin n_fail++; $display("FAIL t6_wr_en_idle: got %h want 0", wr_en); end
    tick();
    n_vec++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL t6_rsp_valid: got %b want 01", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'h1122AAAA) begin n_fail++; $display("FAIL t6_rsp_rdata: got %h want 1122aaaa", rsp_rdata); end
    n_vec++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL t6_rsp_err: got %b want 0", rsp_err); end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    test_reset();
    test_rw_basic();
    test_starvation();
    test_err_read();
    test_err_write();
    test_reset_inflight();
    test_partial_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
